criq_alloc_stage: RTL and testbench
===================================

Name: criq_alloc_stage

Overview:
- Allocation stage directly downstream of the 9-entry free-tag queue (CRIQ).
- Accepts decoded uops, pops one free tag per uop and presents a registered (payload, tag) pair to the next stage over valid/ready.
- Also returns retired tags to the queue and fans flush out to it.
- Uses the queue's look-ahead output, so there are no bubbles between back-to-back pops.

Parameters:
- CRIQWIDE, 5, tag width; matches the queue data width.
- PAYLOADW, 32, uop payload width.

Ports:
- Clk  in  1  clock, all state on posedge.
- Rest  in  1  synchronous reset, active-high.
- InValid  in  1  upstream uop valid.
- InPayload  in  PAYLOADW  upstream uop.
- InReady  out  1  stage can accept this cycle.
- OutValid  out  1  tagged uop valid.
- OutPayload  out  PAYLOADW  registered payload.
- OutTag  out  CRIQWIDE  allocated tag.
- OutReady  in  1  downstream accepts.
- CriqPreOut  in  CRIQWIDE  queue head value (combinational).
- CriqEmpty  in  1  queue empty.
- CriqFull  in  1  queue full.
- CriqRable  out  1  pop strobe to queue.
- CriqWable  out  1  push strobe to queue.
- CriqDin  out  CRIQWIDE  tag pushed back.
- CriqClean  out  1  queue reinit strobe.
- Flush  in  1  backend flush.
- RetValid  in  1  a tag is retired.
- RetTag  in  CRIQWIDE  retired tag.
- OverflowErr  out  1  sticky: push attempted while full.
- StallCnt  out  16  perf counter (see Optional Feature).
- AllocCnt  out  16  perf counter (see Optional Feature).

Behaviour:
- Reset (Rest=1 at posedge):
  - OutValid=0, OutPayload=0, OutTag=0.
  - CriqWable=0, CriqDin=0, OverflowErr=0.
  - Counters=0, state=RUN.
- FSM has two states: RUN and FLUSH_WAIT.
- In RUN:
  - Hold = OutValid && !OutReady.
  - InReady = !CriqEmpty && !Hold && !Flush.
  - Accept = InValid && InReady.
  - CriqRable = Accept (combinational, same cycle).
- On Accept:
  - OutPayload <= InPayload, OutTag <= CriqPreOut, OutValid <= 1.
  - Latency is 1 cycle from input handshake to OutValid.
- If OutReady && OutValid && !Accept: OutValid <= 0.
- While Hold: OutPayload and OutTag are stable and no pop occurs.
- CriqEmpty with InValid: InReady=0 and no pop. An already-registered output may still drain.
- Flush at cycle t, any state:
  - CriqClean=1 combinationally in t.
  - Accept forced 0 in t; any RetValid in t is dropped.
  - At t+1: OutValid=0, CriqWable=0, state=FLUSH_WAIT.
- FLUSH_WAIT:
  - InReady=0, CriqRable=0; retire pushes still accepted.
  - Next state is RUN unless Flush is asserted again.
  - The cycle exists so the queue pointers settle after reinit.
- Retire path:
  - RetValid && !Flush at t gives CriqWable=1, CriqDin=RetTag at t+1 for one cycle.
  - This is a single register stage, one tag per cycle, back-to-back allowed.
- If RetValid && CriqFull at t:
  - The push is still forwarded.
  - OverflowErr <= 1, sticky until Rest.
- Pop and push in the same cycle are legal; the queue handles both.
- Reset mid-operation: all state returns to reset values on the next edge. An in-flight output is discarded, not flushed.
- Tag width: there is no arithmetic on tags; they pass through.

Optional Feature:
- Macro: CRIQ_ALLOC_PERF_EN.
- Defined:
  - StallCnt increments each RUN cycle with InValid && CriqEmpty.
  - AllocCnt increments on each Accept.
  - Both saturate at 16'hFFFF and clear on Rest or Flush.
- Undefined: StallCnt and AllocCnt are tied to 0 and no counter flops are inferred.

Decomposition:
- Shared package holds:
  - CRIQWIDE default (5).
  - FSM state encoding (RUN=1'b0, FLUSH_WAIT=1'b1).
  - Perf counter width (16).
- Natural sub-module: criq_ret_reg, the retire push register plus overflow detection. Everything else stays in one module.

Test Plan:
- Queue freshly reset, InValid held with payloads A,B,C, OutReady=1 -> OutTag 1,5,9 on consecutive cycles; CriqRable high 3 cycles.
- OutReady=0 for 3 cycles after first accept -> OutValid stays 1, OutTag=1 stable, InReady=0, no pops; release gives next tag 5.
- Drain the queue to empty with 8 accepts -> 9th request sees InReady=0, CriqRable=0; RetValid tag 13 then gives the next accept OutTag=13 two cycles later.
- Flush with OutValid=1 and RetValid=1 -> CriqClean pulse 1 cycle, OutValid=0 next cycle, CriqWable stays 0, InReady=0 for exactly 1 FLUSH_WAIT cycle, first accept after gets tag 1.
- RetValid while CriqFull=1 -> CriqWable pulses next cycle and OverflowErr=1; it stays 1 through a Flush and clears only on Rest.
- With CRIQ_ALLOC_PERF_EN, 4 stall cycles then 2 accepts -> StallCnt=4, AllocCnt=2; Flush clears both; undefined build reads 0.

Source files
------------

// File: rtl/criq_alloc_stage_pkg.sv
// Shared definitions for the CRIQ allocation stage: tag width default,
// FSM state encoding and perf counter type.
package criq_alloc_stage_pkg;

    localparam int CRIQWIDE_DEF = 5;
    localparam int PERF_W       = 16;

    typedef logic [PERF_W-1:0] perf_t;

    localparam perf_t PERF_ONE = perf_t'(1);
    localparam perf_t PERF_MAX = '1;

    typedef enum logic {
        RUN        = 1'b0,
        FLUSH_WAIT = 1'b1
    } alloc_state_e;

    // Saturating increment shared by both perf counters.
    function automatic perf_t perf_inc(input perf_t cnt);
        return (cnt == PERF_MAX) ? cnt : cnt + PERF_ONE;
    endfunction

endpackage

// File: rtl/criq_ret_reg.sv
// Retire push register: forwards one retired tag per cycle to the free-tag
// queue and records a sticky overflow if a push is attempted while full.
module criq_ret_reg #(
    parameter int CRIQWIDE = 5
) (
    input  logic                Clk,
    input  logic                Rest,
    input  logic                i_ret_valid,
    input  logic [CRIQWIDE-1:0] i_ret_tag,
    input  logic                i_flush,
    input  logic                i_full,
    output logic                o_wable,
    output logic [CRIQWIDE-1:0] o_din,
    output logic                o_overflow
);

    logic                r_wable;
    logic [CRIQWIDE-1:0] r_din;
    logic                r_overflow;
    logic                w_push;

    // A flush discards the retire in the same cycle; the queue is being reinitialised.
    assign w_push = i_ret_valid && !i_flush;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Rest) begin
            r_wable    <= 1'b0;
            r_din      <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_wable <= w_push;
            if (w_push) begin
                r_din <= i_ret_tag;
            end
            if (w_push && i_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_wable    = r_wable;
    assign o_din      = r_din;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/criq_alloc_stage.sv
// Allocation stage: pops one free tag per accepted uop and registers the
// (payload, tag) pair. Optional perf counters under `CRIQ_ALLOC_PERF_EN.
module criq_alloc_stage
    import criq_alloc_stage_pkg::*;
#(
    parameter int CRIQWIDE = CRIQWIDE_DEF,
    parameter int PAYLOADW = 32
) (
    input  logic                Clk,
    input  logic                Rest,
    input  logic                InValid,
    input  logic [PAYLOADW-1:0] InPayload,
    output logic                InReady,
    output logic                OutValid,
    output logic [PAYLOADW-1:0] OutPayload,
    output logic [CRIQWIDE-1:0] OutTag,
    input  logic                OutReady,
    input  logic [CRIQWIDE-1:0] CriqPreOut,
    input  logic                CriqEmpty,
    input  logic                CriqFull,
    output logic                CriqRable,
    output logic                CriqWable,
    output logic [CRIQWIDE-1:0] CriqDin,
    output logic                CriqClean,
    input  logic                Flush,
    input  logic                RetValid,
    input  logic [CRIQWIDE-1:0] RetTag,
    output logic                OverflowErr,
    output logic [PERF_W-1:0]   StallCnt,
    output logic [PERF_W-1:0]   AllocCnt
);

    alloc_state_e        r_state;
    logic                r_out_valid;
    logic [PAYLOADW-1:0] r_out_payload;
    logic [CRIQWIDE-1:0] r_out_tag;

    logic w_hold;
    logic w_in_ready;
    logic w_accept;

    // The queue's look-ahead head lets the tag be captured in the pop cycle itself.
    assign w_hold     = r_out_valid && !OutReady;
    assign w_in_ready = (r_state == RUN) && !CriqEmpty && !w_hold && !Flush;
    assign w_accept   = InValid && w_in_ready;

    always_ff @(posedge Clk) begin
        if (Rest) begin
            r_state       <= RUN;
            r_out_valid   <= 1'b0;
            r_out_payload <= '0;
            r_out_tag     <= '0;
        end else if (Flush) begin
            r_state     <= FLUSH_WAIT;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_accept) begin
                        r_out_valid   <= 1'b1;
                        r_out_payload <= InPayload;
                        r_out_tag     <= CriqPreOut;
                    end else if (OutReady) begin
                        r_out_valid <= 1'b0;
                    end
                end
                FLUSH_WAIT: begin
                    r_state <= RUN;
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end

    criq_ret_reg #(
        .CRIQWIDE (CRIQWIDE)
    ) u_ret_reg (
        .Clk         (Clk),
        .Rest        (Rest),
        .i_ret_valid (RetValid),
        .i_ret_tag   (RetTag),
        .i_flush     (Flush),
        .i_full      (CriqFull),
        .o_wable     (CriqWable),
        .o_din       (CriqDin),
        .o_overflow  (OverflowErr)
    );

`ifdef CRIQ_ALLOC_PERF_EN
    perf_t r_stall_cnt;
    perf_t r_alloc_cnt;
    logic  w_stall;

    assign w_stall = (r_state == RUN) && InValid && CriqEmpty;

    always_ff @(posedge Clk) begin
        if (Rest || Flush) begin
            r_stall_cnt <= '0;
            r_alloc_cnt <= '0;
        end else begin
            if (w_stall) begin
                r_stall_cnt <= perf_inc(r_stall_cnt);
            end
            if (w_accept) begin
                r_alloc_cnt <= perf_inc(r_alloc_cnt);
            end
        end
    end

    assign StallCnt = r_stall_cnt;
    assign AllocCnt = r_alloc_cnt;
`else
    assign StallCnt = '0;
    assign AllocCnt = '0;
`endif

    assign InReady    = w_in_ready;
    assign CriqRable  = w_accept;
    assign CriqClean  = Flush;
    assign OutValid   = r_out_valid;
    assign OutPayload = r_out_payload;
    assign OutTag     = r_out_tag;

endmodule

// File: tb/tb_criq_alloc_stage.sv
// Directed bench for criq_alloc_stage with a small free-tag queue model that
// reinitialises to tags 1,5,9,...,29 (8 entries, capacity 9).
module tb_criq_alloc_stage;

    localparam int TW = 5;
    localparam int PW = 32;

    logic          Clk;
    logic          Rest;
    logic          InValid;
    logic [PW-1:0] InPayload;
    logic          InReady;
    logic          OutValid;
    logic [PW-1:0] OutPayload;
    logic [TW-1:0] OutTag;
    logic          OutReady;
    logic [TW-1:0] CriqPreOut;
    logic          CriqEmpty;
    logic          CriqFull;
    logic          CriqRable;
    logic          CriqWable;
    logic [TW-1:0] CriqDin;
    logic          CriqClean;
    logic          Flush;
    logic          RetValid;
    logic [TW-1:0] RetTag;
    logic          OverflowErr;
    logic [15:0]   StallCnt;
    logic [15:0]   AllocCnt;

    int n_cmp = 0;
    int n_bad = 0;

    criq_alloc_stage #(.CRIQWIDE(TW), .PAYLOADW(PW)) dut (
        .Clk(Clk), .Rest(Rest),
        .InValid(InValid), .InPayload(InPayload), .InReady(InReady),
        .OutValid(OutValid), .OutPayload(OutPayload), .OutTag(OutTag), .OutReady(OutReady),
        .CriqPreOut(CriqPreOut), .CriqEmpty(CriqEmpty), .CriqFull(CriqFull),
        .CriqRable(CriqRable), .CriqWable(CriqWable), .CriqDin(CriqDin), .CriqClean(CriqClean),
        .Flush(Flush), .RetValid(RetValid), .RetTag(RetTag),
        .OverflowErr(OverflowErr), .StallCnt(StallCnt), .AllocCnt(AllocCnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Free-tag queue model
    logic [TW-1:0] q_mem [9];
    int            q_head;
    int            q_cnt;
    logic          force_empty;
    logic          q_pop;
    logic          q_push;

    assign q_pop      = CriqRable && (q_cnt != 0);
    assign q_push     = CriqWable && (q_cnt != 9);
    assign CriqPreOut = q_mem[q_head];
    assign CriqEmpty  = (q_cnt == 0) || force_empty;
    assign CriqFull   = (q_cnt == 9);

    always @(posedge Clk) begin
        if (Rest || CriqClean) begin
            for (int i = 0; i < 8; i++) q_mem[i] <= TW'(4 * i + 1);
            q_mem[8] <= '0;
            q_head   <= 0;
            q_cnt    <= 8;
        end else begin
            if (q_push) q_mem[(q_head + q_cnt) % 9] <= CriqDin;
            if (q_pop) q_head <= (q_head + 1) % 9;
            q_cnt <= q_cnt + int'(q_push) - int'(q_pop);
        end
    end

    task automatic do_reset;
        Rest = 1'b1; InValid = 1'b0; InPayload = '0; OutReady = 1'b0;
        Flush = 1'b0; RetValid = 1'b0; RetTag = '0; force_empty = 1'b0;
        @(negedge Clk);
        Rest = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        n_cmp++; if (OutValid !== 1'b0) begin n_bad++; $display("FAIL rst_outvalid got %0b want 0", OutValid); end
        n_cmp++; if (OutTag !== 5'd0) begin n_bad++; $display("FAIL rst_outtag got %0d want 0", OutTag); end
        n_cmp++; if (OutPayload !== 32'd0) begin n_bad++; $display("FAIL rst_payload got %h want 0", OutPayload); end
        n_cmp++; if (CriqWable !== 1'b0 || CriqDin !== 5'd0) begin n_bad++; $display("FAIL rst_ret got %0b/%0d want 0/0", CriqWable, CriqDin); end
        n_cmp++; if (OverflowErr !== 1'b0) begin n_bad++; $display("FAIL rst_ovf got %0b want 0", OverflowErr); end
        n_cmp++; if (StallCnt !== 16'd0 || AllocCnt !== 16'd0) begin n_bad++; $display("FAIL rst_cnt got %0d/%0d want 0/0", StallCnt, AllocCnt); end
        n_cmp++; if (InReady !== 1'b1) begin n_bad++; $display("FAIL rst_inready got %0b want 1", InReady); end
    endtask

    task automatic test_back_to_back;
        logic [PW-1:0] pay [3];
        pay[0] = 32'hAAAA_0001; pay[1] = 32'hBBBB_0002; pay[2] = 32'hCCCC_0003;
        do_reset();
        OutReady = 1'b1; InValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            InPayload = pay[i];
            #1;
            n_cmp++; if (CriqRable !== 1'b1) begin n_bad++; $display("FAIL b2b_rable%0d got %0b want 1", i, CriqRable); end
            @(negedge Clk);
            n_cmp++;
            if (OutValid !== 1'b1 || OutTag !== TW'(4 * i + 1) || OutPayload !== pay[i]) begin
                n_bad++;
                $display("FAIL b2b_out%0d got v=%0b tag=%0d pay=%h want v=1 tag=%0d pay=%h",
                         i, OutValid, OutTag, OutPayload, 4 * i + 1, pay[i]);
            end
        end
        InValid = 1'b0;
        #1;
        n_cmp++; if (CriqRable !== 1'b0) begin n_bad++; $display("FAIL b2b_rable_idle got %0b want 0", CriqRable); end
        @(negedge Clk);
        n_cmp++; if (OutValid !== 1'b0) begin n_bad++; $display("FAIL b2b_drain got %0b want 0", OutValid); end
    endtask

    task automatic test_hold;
        do_reset();
        InValid = 1'b1; InPayload = 32'h0000_00A1; OutReady = 1'b0;
        @(negedge Clk);
        InPayload = 32'h0000_00B2;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (OutValid !== 1'b1 || OutTag !== 5'd1 || OutPayload !== 32'h0000_00A1) begin
                n_bad++;
                $display("FAIL hold_out%0d got v=%0b tag=%0d pay=%h want v=1 tag=1 pay=a1", i, OutValid, OutTag, OutPayload);
            end
            n_cmp++;
            if (InReady !== 1'b0 || CriqRable !== 1'b0) begin
                n_bad++;
                $display("FAIL hold_stall%0d got rdy=%0b rable=%0b want 0/0", i, InReady, CriqRable);
            end
            if (i < 2) @(negedge Clk);
        end
        OutReady = 1'b1;
        #1;
        n_cmp++; if (InReady !== 1'b1) begin n_bad++; $display("FAIL hold_release got %0b want 1", InReady); end
        @(negedge Clk);
        InValid = 1'b0;
        n_cmp++;
        if (OutTag !== 5'd5 || OutPayload !== 32'h0000_00B2) begin
            n_bad++;
            $display("FAIL hold_next got tag=%0d pay=%h want tag=5 pay=b2", OutTag, OutPayload);
        end
    endtask

    task automatic test_drain_empty;
        do_reset();
        OutReady = 1'b1; InValid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            InPayload = PW'(i);
            @(negedge Clk);
            n_cmp++;
            if (OutTag !== TW'(4 * i + 1)) begin n_bad++; $display("FAIL drain_tag%0d got %0d want %0d", i, OutTag, 4 * i + 1); end
        end
        #1;
        n_cmp++;
        if (InReady !== 1'b0 || CriqRable !== 1'b0) begin
            n_bad++;
            $display("FAIL drain_empty got rdy=%0b rable=%0b want 0/0", InReady, CriqRable);
        end
        RetValid = 1'b1; RetTag = 5'd13;
        @(negedge Clk);
        RetValid = 1'b0;
        n_cmp++;
        if (CriqWable !== 1'b1 || CriqDin !== 5'd13) begin
            n_bad++;
            $display("FAIL drain_push got w=%0b din=%0d want 1/13", CriqWable, CriqDin);
        end
        n_cmp++; if (OutValid !== 1'b0) begin n_bad++; $display("FAIL drain_outdrained got %0b want 0", OutValid); end
        @(negedge Clk);
        n_cmp++; if (InReady !== 1'b1) begin n_bad++; $display("FAIL drain_refill got %0b want 1", InReady); end
        @(negedge Clk);
        InValid = 1'b0;
        n_cmp++;
        if (OutValid !== 1'b1 || OutTag !== 5'd13) begin
            n_bad++;
            $display("FAIL drain_retag got v=%0b tag=%0d want 1/13", OutValid, OutTag);
        end
    endtask

    task automatic test_flush;
        do_reset();
        InValid = 1'b1; InPayload = 32'h1234_5678; OutReady = 1'b0;
        @(negedge Clk);
        Flush = 1'b1; RetValid = 1'b1; RetTag = 5'd7;
        #1;
        n_cmp++;
        if (CriqClean !== 1'b1 || InReady !== 1'b0 || CriqRable !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_now got clean=%0b rdy=%0b rable=%0b want 1/0/0", CriqClean, InReady, CriqRable);
        end
        @(negedge Clk);
        Flush = 1'b0; RetValid = 1'b0; OutReady = 1'b1;
        #1;
        n_cmp++;
        if (OutValid !== 1'b0 || CriqWable !== 1'b0 || CriqClean !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_next got v=%0b w=%0b clean=%0b want 0/0/0", OutValid, CriqWable, CriqClean);
        end
        n_cmp++; if (InReady !== 1'b0) begin n_bad++; $display("FAIL flush_wait got %0b want 0", InReady); end
        @(negedge Clk);
        n_cmp++; if (InReady !== 1'b1) begin n_bad++; $display("FAIL flush_resume got %0b want 1", InReady); end
        @(negedge Clk);
        InValid = 1'b0;
        n_cmp++;
        if (OutValid !== 1'b1 || OutTag !== 5'd1) begin
            n_bad++;
            $display("FAIL flush_tag got v=%0b tag=%0d want 1/1", OutValid, OutTag);
        end
    endtask

    task automatic test_overflow;
        do_reset();
        RetValid = 1'b1; RetTag = 5'd3;
        @(negedge Clk);
        RetValid = 1'b0;
        n_cmp++; if (OverflowErr !== 1'b0) begin n_bad++; $display("FAIL ovf_notfull got %0b want 0", OverflowErr); end
        @(negedge Clk);
        RetValid = 1'b1; RetTag = 5'd4;
        @(negedge Clk);
        RetValid = 1'b0;
        n_cmp++;
        if (CriqWable !== 1'b1 || CriqDin !== 5'd4 || OverflowErr !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_set got w=%0b din=%0d ovf=%0b want 1/4/1", CriqWable, CriqDin, OverflowErr);
        end
        Flush = 1'b1;
        @(negedge Clk);
        Flush = 1'b0;
        n_cmp++; if (OverflowErr !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got %0b want 1", OverflowErr); end
        do_reset();
        n_cmp++; if (OverflowErr !== 1'b0) begin n_bad++; $display("FAIL ovf_clear got %0b want 0", OverflowErr); end
    endtask

    task automatic test_perf;
        logic [15:0] exp_stall;
        logic [15:0] exp_alloc;
`ifdef CRIQ_ALLOC_PERF_EN
        exp_stall = 16'd4; exp_alloc = 16'd2;
`else
        exp_stall = 16'd0; exp_alloc = 16'd0;
`endif
        do_reset();
        OutReady = 1'b1; InValid = 1'b1; force_empty = 1'b1;
        repeat (4) @(negedge Clk);
        force_empty = 1'b0;
        repeat (2) @(negedge Clk);
        InValid = 1'b0;
        n_cmp++;
        if (StallCnt !== exp_stall || AllocCnt !== exp_alloc) begin
            n_bad++;
            $display("FAIL perf_count got %0d/%0d want %0d/%0d", StallCnt, AllocCnt, exp_stall, exp_alloc);
        end
        Flush = 1'b1;
        @(negedge Clk);
        Flush = 1'b0;
        n_cmp++;
        if (StallCnt !== 16'd0 || AllocCnt !== 16'd0) begin
            n_bad++;
            $display("FAIL perf_flush got %0d/%0d want 0/0", StallCnt, AllocCnt);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_hold();
        test_drain_empty();
        test_flush();
        test_overflow();
        test_perf();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
